mips_register_file: RTL



---
 rtl/mips_pkg.sv | 26 ++
 rtl/regfile_read_port.sv | 59 +++++
 rtl/mips_register_file.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Constants shared by the register file, the write-register select mux and
//   the control unit of the single-cycle MIPS datapath.
//
//   REG_ADDR_W / REG_DATA_W : architectural register address / data widths
//   REG_ZERO                : hardwired-zero register ($zero)
//   REG_RA                  : return-address register ($ra, jal target)
//   WCNT_W                  : width of the committed-write counter
//   sat_inc                 : saturating increment for the write counter
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  localparam int unsigned WCNT_W = 16;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One purely combinational read path of the register file: array select,
//   register-0 force and (build option REGFILE_BYPASS_EN) a write-to-read
//   bypass comparator.
//
//   Parameters : DATA_W, ADDR_W (depth = 2**ADDR_W)
//   Ports      :
//     raddr       in   ADDR_W        read address
//     mem         in   DEPTH*DATA_W  flattened storage array from the top
//     reg_write   in   1             write enable       (bypass build only)
//     write_reg   in   ADDR_W        write address      (bypass build only)
//     write_data  in   DATA_W        write-back value   (bypass build only)
//     rdata       out  DATA_W        read result
//
//   Macro REGFILE_BYPASS_EN: when defined, a write in flight to the address
//   being read is forwarded in the same cycle. When undefined the write-side
//   ports do not exist and no comparator is built.
// ---------------------------------------------------------------------------
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                    raddr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   mem,
`ifdef REGFILE_BYPASS_EN
  input  logic                                 reg_write,
  input  logic [ADDR_W-1:0]                    write_reg,
  input  logic [DATA_W-1:0]                    write_data,
`endif
  output logic [DATA_W-1:0]                    rdata
);

  logic raddr_zero;
  assign raddr_zero = (raddr == '0);

`ifdef REGFILE_BYPASS_EN
  // Deliberately not gated by reset: the forwarded value is whatever is on
  // the write-back bus this cycle, regardless of whether it will commit.
  logic byp_hit;
  assign byp_hit = reg_write && (write_reg != '0) && (write_reg == raddr);

  always_comb begin
    rdata = mem[raddr];
    if (byp_hit)    rdata = write_data;
    if (raddr_zero) rdata = '0;
  end
`else
  // Entry 0 is never written, but force it anyway so $zero does not depend
  // on the storage array holding its reset value.
  always_comb begin
    rdata = mem[raddr];
    if (raddr_zero) rdata = '0;
  end
`endif

endmodule

// File: rtl/mips_register_file.sv
// ---------------------------------------------------------------------------
// mips_register_file
//   32 x 32-bit general-purpose register file for the single-cycle MIPS
//   datapath. Two combinational read ports (rs, rt), one synchronous write
//   port fed by the write-register select mux, $zero hardwired to 0 and a
//   saturating count of committed writes.
//
//   Parameters : DATA_W (32), ADDR_W (5, depth = 2**ADDR_W)
//   Ports      :
//     clk          in   1       rising-edge clock
//     reset        in   1       synchronous, active-high; clears all state
//     read_reg1    in   ADDR_W  rs address
//     read_reg2    in   ADDR_W  rt address
//     write_reg    in   ADDR_W  destination register
//     write_data   in   DATA_W  write-back value
//     reg_write    in   1       write enable
//     read_data1   out  DATA_W  contents of read_reg1
//     read_data2   out  DATA_W  contents of read_reg2
//     write_count  out  16      committed writes since reset, saturating
//
//   Macro REGFILE_BYPASS_EN: define to forward write_data to a read port
//   whose address matches a same-cycle write (non-zero address).
// ---------------------------------------------------------------------------
module mips_register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [WCNT_W-1:0] write_count
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NPORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [WCNT_W-1:0]            wcnt;

  // A write to $zero is dropped entirely: no storage update, no count.
  logic wr_commit;
  assign wr_commit = reg_write && (write_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      wcnt <= '0;
    end else if (wr_commit) begin
      mem[write_reg] <= write_data;
      wcnt           <= sat_inc(wcnt);
    end
  end

  assign write_count = wcnt;

  // ---- read ports --------------------------------------------------------
  logic [NPORTS-1:0][ADDR_W-1:0] raddr;
  logic [NPORTS-1:0][DATA_W-1:0] rdata;

  assign raddr[0] = read_reg1;
  assign raddr[1] = read_reg2;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rp
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rp (
      .raddr      (raddr[gi]),
      .mem        (mem),
`ifdef REGFILE_BYPASS_EN
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
`endif
      .rdata      (rdata[gi])
    );
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];

endmodule
